// File: rtl/pipe_scroller.sv
// pipe_scroller: position generator for the scrolling Flappy pipe pair (IDLE/RUN/RESPAWN/HALT).
// Define PIPE_SCROLLER_SCORE_EN to build the saturating pass counter behind the score port.
module pipe_scroller #(
    parameter int unsigned TICK_DIV    = 500000,
    parameter logic [9:0]  X_SPAWN     = 10'd834,
    parameter logic [9:0]  X_EXIT      = 10'd94,
    parameter logic [9:0]  PASS_X      = 10'd290,
    parameter logic [9:0]  PIPE_Y_MIN  = 10'd75,
    parameter logic [9:0]  PIPE_Y_INIT = 10'd200,
    parameter logic [9:0]  LFSR_SEED   = 10'h2A5,
    parameter int unsigned RAMP_PIPES  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button,
    input  logic        halt,
    output logic [9:0]  PipeX,
    output logic [9:0]  PipeY,
    output logic        pass_pulse,
    output logic        running,
    output logic [1:0]  speed_level,
    output logic [15:0] score,
    output logic [1:0]  fsm_state
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RESPAWN = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam int unsigned  RW        = $clog2(RAMP_PIPES + 1);
    localparam logic [19:0]  TICK_LAST = 20'(TICK_DIV - 1);
    localparam logic [RW-1:0] RESP_LAST = RW'(RAMP_PIPES - 1);

    state_t        state, state_next;
    logic [2:0]    btn_sync;
    logic          start_edge, tick, exit_now;
    logic          cross_pend, cross_d, pass_d;
    logic [19:0]   tick_cnt;
    logic [9:0]    step, x_moved, lfsr, lfsr_next, lfsr_d, x_d, y_d;
    logic [1:0]    lvl_d;
    logic [RW-1:0] resp_cnt, resp_d;

    // Two flops for metastability, the third remembers the previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_sync <= '0;
        else        btn_sync <= {btn_sync[1:0], button};
    end
    assign start_edge = btn_sync[1] & ~btn_sync[2];

    assign tick = (state == S_RUN) && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             tick_cnt <= '0;
        else if (state != S_RUN || tick)        tick_cnt <= '0;
        else                                    tick_cnt <= tick_cnt + 20'd1;
    end

    assign step      = 10'(speed_level) + 10'd1;
    assign x_moved   = PipeX - step;
    // Widened compare so PipeX - step can never wrap below zero.
    assign exit_now  = {1'b0, PipeX} < ({1'b0, X_EXIT} + {1'b0, step});
    assign lfsr_next = {lfsr[8:0], lfsr[9] ^ lfsr[6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start_edge) state_next = S_RUN;
            S_RUN:     if (halt) state_next = S_HALT;
                       else if (tick && exit_now) state_next = S_RESPAWN;
            S_RESPAWN: state_next = halt ? S_HALT : S_RUN;
            S_HALT:    if (start_edge && !halt) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        x_d     = PipeX;
        y_d     = PipeY;
        lfsr_d  = lfsr;
        lvl_d   = speed_level;
        resp_d  = resp_cnt;
        cross_d = 1'b0;
        case (state)
            S_IDLE: begin
                x_d = X_SPAWN;
                y_d = PIPE_Y_INIT;
                if (start_edge) begin
                    lvl_d  = 2'd0;
                    resp_d = '0;
                end
            end
            S_RUN: begin
                if (!halt && tick && !exit_now) begin
                    x_d     = x_moved;
                    cross_d = (PipeX >= PASS_X) && (x_moved < PASS_X);
                end
            end
            S_RESPAWN: begin
                if (!halt) begin
                    lfsr_d = lfsr_next;
                    y_d    = PIPE_Y_MIN + {2'b00, lfsr_next[7:0]};
                    x_d    = X_SPAWN;
                    if (resp_cnt == RESP_LAST) begin
                        resp_d = '0;
                        lvl_d  = (speed_level == 2'd3) ? 2'd3 : speed_level + 2'd1;
                    end else begin
                        resp_d = resp_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // The crossing is flagged at the move edge and published one cycle later, unless the game halts.
    assign pass_d = cross_pend && (state_next != S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PipeX       <= X_SPAWN;
            PipeY       <= PIPE_Y_INIT;
            pass_pulse  <= 1'b0;
            running     <= 1'b0;
            speed_level <= 2'd0;
            lfsr        <= LFSR_SEED;
            resp_cnt    <= '0;
            cross_pend  <= 1'b0;
        end else begin
            PipeX       <= x_d;
            PipeY       <= y_d;
            pass_pulse  <= pass_d;
            running     <= (state == S_RUN) || (state == S_RESPAWN);
            speed_level <= lvl_d;
            lfsr        <= lfsr_d;
            resp_cnt    <= resp_d;
            cross_pend  <= cross_d;
        end
    end

    assign fsm_state = state;

`ifdef PIPE_SCROLLER_SCORE_EN
    logic [15:0] score_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                score_q <= '0;
        else if (state == S_IDLE && start_edge)    score_q <= '0;
        else if (pass_d && score_q != 16'hFFFF)    score_q <= score_q + 16'd1;
    end
    assign score = score_q;
`else
    assign score = 16'd0;
`endif

endmodule
